// File: rtl/spi_fl_pkg.sv
// spi_fl_pkg: shared widths, commtype encodings, arbiter state encodings and request record
package spi_fl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int COM_W  = 8;
  localparam int CTYP_W = 3;
  localparam int NMISO_W = 7;
  localparam int DUMMY_W = 4;
  typedef enum logic [CTYP_W-1:0] {
    CMD_ONLY      = 3'd0,
    CMD_ANS       = 3'd1,
    CMD_ADDR_ANS  = 3'd2,
    CMD_DATA      = 3'd3,
    CMD_ADDR_DATA = 3'd4,
    CMD_ADDR      = 3'd5
  } commtype_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic [COM_W-1:0]   cmd;
    logic [CTYP_W-1:0]  ctyp;
    logic [NMISO_W-1:0] nmiso;
    logic [DUMMY_W-1:0] dummy;
  } req_t;
endpackage

// File: rtl/spi_fl_arbiter_if.sv
// spi_fl_arbiter_if: bundle of both requester ports, both response ports and the flash master link
// slave modport: arbiter view (requests/master status in, accepts/responses/master fields out)
// master modport: requester + flash master view (the mirror image)
interface spi_fl_arbiter_if;
  import spi_fl_pkg::*;
  logic               req0_valid, req0_ready;
  logic [COM_W-1:0]   req0_command;
  logic [ADDR_W-1:0]  req0_address;
  logic [DATA_W-1:0]  req0_data;
  logic [CTYP_W-1:0]  req0_commtype;
  logic [NMISO_W-1:0] req0_nmiso;
  logic [DUMMY_W-1:0] req0_dummy;
  logic               resp0_valid, resp0_err;
  logic [DATA_W-1:0]  resp0_data;
  logic               req1_valid, req1_ready;
  logic [COM_W-1:0]   req1_command;
  logic [ADDR_W-1:0]  req1_address;
  logic [DATA_W-1:0]  req1_data;
  logic [CTYP_W-1:0]  req1_commtype;
  logic [NMISO_W-1:0] req1_nmiso;
  logic [DUMMY_W-1:0] req1_dummy;
  logic               resp1_valid, resp1_err;
  logic [DATA_W-1:0]  resp1_data;
  logic [DATA_W-1:0]  m_data_in;
  logic [ADDR_W-1:0]  m_address;
  logic [COM_W-1:0]   m_command;
  logic [CTYP_W-1:0]  m_commtype;
  logic [NMISO_W-1:0] m_nmiso_bits;
  logic [DUMMY_W-1:0] m_dummy_cycles;
  logic               m_validflag;
  logic               m_tready;
  logic [DATA_W-1:0]  m_data_out;
  modport slave (
    input  req0_valid, req0_command, req0_address, req0_data, req0_commtype, req0_nmiso, req0_dummy,
    input  req1_valid, req1_command, req1_address, req1_data, req1_commtype, req1_nmiso, req1_dummy,
    output req0_ready, resp0_valid, resp0_err, resp0_data,
    output req1_ready, resp1_valid, resp1_err, resp1_data,
    output m_data_in, m_address, m_command, m_commtype, m_nmiso_bits, m_dummy_cycles, m_validflag,
    input  m_tready, m_data_out
  );
  modport master (
    output req0_valid, req0_command, req0_address, req0_data, req0_commtype, req0_nmiso, req0_dummy,
    output req1_valid, req1_command, req1_address, req1_data, req1_commtype, req1_nmiso, req1_dummy,
    input  req0_ready, resp0_valid, resp0_err, resp0_data,
    input  req1_ready, resp1_valid, resp1_err, resp1_data,
    input  m_data_in, m_address, m_command, m_commtype, m_nmiso_bits, m_dummy_cycles, m_validflag,
    output m_tready, m_data_out
  );
endinterface

// File: rtl/spi_fl_rr2.sv
// spi_fl_rr2: two-input round-robin picker
// i_req: request vector, i_last: port served last, o_any: some request, o_gnt: chosen port
module spi_fl_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_gnt
);
  assign o_any = |i_req;
  assign o_gnt = &i_req ? ~i_last : i_req[1];
endmodule

// File: rtl/spi_fl_arbiter.sv
// spi_fl_arbiter: round-robin two-port sequencer in front of the flash SPI master
// clk/rst: clock and async active-high reset; bus: requester ports, responses and master link
module spi_fl_arbiter #(
  parameter int ACCEPT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  spi_fl_arbiter_if.slave  bus
);
  import spi_fl_pkg::*;
  localparam logic [7:0] TO_LAST = 8'(ACCEPT_TIMEOUT - 1);
  state_t            r_state, w_state;
  logic              r_last, w_last, r_port, w_port, r_vf, w_vf;
  logic [7:0]        r_cnt, w_cnt;
  req_t              r_f, w_f, w_q0, w_q1;
  logic [1:0]        r_rdy, w_rdy, r_rv, w_rv, r_rerr, w_rerr;
  logic [DATA_W-1:0] r_rd0, w_rd0, r_rd1, w_rd1;
  logic              w_any, w_gnt, w_grant, w_accept, w_tout, w_done, w_fin;
  assign w_q0 = {bus.req0_data, bus.req0_address, bus.req0_command, bus.req0_commtype, bus.req0_nmiso, bus.req0_dummy};
  assign w_q1 = {bus.req1_data, bus.req1_address, bus.req1_command, bus.req1_commtype, bus.req1_nmiso, bus.req1_dummy};
  spi_fl_rr2 u_rr (
    .i_req  ({bus.req1_valid, bus.req0_valid}),
    .i_last (r_last),
    .o_any  (w_any),
    .o_gnt  (w_gnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_vf    <= 1'b0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_rdy   <= '0;
      r_rv    <= '0;
      r_rerr  <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_port  <= w_port;
      r_vf    <= w_vf;
      r_cnt   <= w_cnt;
      r_f     <= w_f;
      r_rdy   <= w_rdy;
      r_rv    <= w_rv;
      r_rerr  <= w_rerr;
      r_rd0   <= w_rd0;
      r_rd1   <= w_rd1;
    end
  // an acknowledge seen on the last counted cycle still wins over the timeout
  always_comb
    w_state = r_state == S_IDLE  ? (w_any && bus.m_tready ? S_ISSUE : S_IDLE) :
              r_state == S_ISSUE ? (!bus.m_tready ? S_BUSY : r_cnt == TO_LAST ? S_IDLE : S_ISSUE) :
                                   (bus.m_tready ? S_IDLE : S_BUSY);
  always_comb begin
    w_grant  = r_state == S_IDLE && w_any && bus.m_tready;
    w_accept = r_state == S_ISSUE && !bus.m_tready;
    w_tout   = r_state == S_ISSUE && bus.m_tready && r_cnt == TO_LAST;
    w_done   = r_state == S_BUSY && bus.m_tready;
    w_fin    = w_tout || w_done;
    w_port   = w_grant ? w_gnt : r_port;
    w_f      = w_grant ? (w_gnt ? w_q1 : w_q0) : r_f;
    w_vf     = w_grant ? 1'b1 : (w_accept || w_tout) ? 1'b0 : r_vf;
    w_cnt    = w_grant ? 8'd0 : r_state == S_ISSUE ? r_cnt + 8'd1 : r_cnt;
    w_rdy    = w_grant ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    w_rv     = w_fin ? (r_port ? 2'b10 : 2'b01) : 2'b00;
    w_rerr   = w_tout ? w_rv : 2'b00;
    w_rd0    = w_fin && !r_port ? (w_tout ? '0 : bus.m_data_out) : r_rd0;
    w_rd1    = w_fin && r_port ? (w_tout ? '0 : bus.m_data_out) : r_rd1;
    w_last   = w_fin ? r_port : r_last;
  end
  assign bus.req0_ready     = r_rdy[0];
  assign bus.req1_ready     = r_rdy[1];
  assign bus.resp0_valid    = r_rv[0];
  assign bus.resp1_valid    = r_rv[1];
  assign bus.resp0_err      = r_rerr[0];
  assign bus.resp1_err      = r_rerr[1];
  assign bus.resp0_data     = r_rd0;
  assign bus.resp1_data     = r_rd1;
  assign bus.m_data_in      = r_f.data;
  assign bus.m_address      = r_f.addr;
  assign bus.m_command      = r_f.cmd;
  assign bus.m_commtype     = r_f.ctyp;
  assign bus.m_nmiso_bits   = r_f.nmiso;
  assign bus.m_dummy_cycles = r_f.dummy;
  assign bus.m_validflag    = r_vf;
endmodule

// File: tb/tb_spi_fl_arbiter.sv
// tb_spi_fl_arbiter: directed self-checking bench for spi_fl_arbiter with a behavioural flash master
module tb_spi_fl_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_fl_arbiter_if bus ();
  spi_fl_arbiter #(.ACCEPT_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_pass = 0, n_fail = 0, n_chk = 0, n_r0 = 0, n_r1 = 0;
  int n, k, hi;
  int g[$];
  logic mm_tr, mm_ack = 1'b1, mm_hold0 = 1'b0;
  int mm_cnt;
  logic [31:0] mm_rdata = '0, mm_dout;
  localparam int MM_BUSY = 4;
  assign bus.m_tready   = mm_tr & ~mm_hold0;
  assign bus.m_data_out = mm_dout;
  // flash master: goes busy 2-3 clk after validflag, stays busy MM_BUSY clk, then returns mm_rdata
  always @(posedge clk or posedge rst)
    if (rst) begin
      mm_tr <= 1'b1;
      mm_cnt <= 0;
      mm_dout <= '0;
    end else if (mm_cnt == 0) begin
      if (bus.m_validflag && mm_ack) mm_cnt <= 1;
    end else begin
      mm_cnt <= mm_cnt + 1;
      if (mm_cnt == 2) mm_tr <= 1'b0;
      if (mm_cnt == 2 + MM_BUSY) begin
        mm_tr <= 1'b1;
        mm_dout <= mm_rdata;
        mm_cnt <= 0;
      end
    end
  always @(posedge clk) begin
    if (bus.resp0_valid) n_r0++;
    if (bus.resp1_valid) n_r1++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? bus.req0_ready : w == 1 ? bus.req1_ready : w == 2 ? bus.resp0_valid : bus.resp1_valid;
  endfunction
  task automatic wait_for(input int w, input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sig(w) && cnt < 50);
    chk(tag, {31'd0, sig(w)}, 32'd1);
  endtask
  task automatic set_req(input int p, input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input logic [6:0] nm, input logic [3:0] dm);
    if (p == 0) begin
      bus.req0_command = c; bus.req0_address = a; bus.req0_data = d;
      bus.req0_commtype = t; bus.req0_nmiso = nm; bus.req0_dummy = dm;
    end else begin
      bus.req1_command = c; bus.req1_address = a; bus.req1_data = d;
      bus.req1_commtype = t; bus.req1_nmiso = nm; bus.req1_dummy = dm;
    end
  endtask
  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    set_req(0, 8'h00, 32'h0, 32'h0, 3'd0, 7'd0, 4'd0);
    set_req(1, 8'h00, 32'h0, 32'h0, 3'd0, 7'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rst_vf", {31'd0, bus.m_validflag}, 0);
    chk("rst_addr", bus.m_address, 0);
    chk("rst_din", bus.m_data_in, 0);
    chk("rst_cmd", {24'd0, bus.m_command}, 0);
    chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
    chk("rst_resp", {28'd0, bus.resp1_err, bus.resp1_valid, bus.resp0_err, bus.resp0_valid}, 0);
    chk("rst_rdata0", bus.resp0_data, 0);
    chk("rst_rdata1", bus.resp1_data, 0);
    mm_hold0 = 1'b1;
    mm_rdata = 32'h00C22017;
    set_req(0, 8'h9F, 32'h0, 32'h0, 3'd1, 7'd24, 4'd0);
    bus.req0_valid = 1'b1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_tready0_nogrant", {31'd0, bus.req0_ready}, 0);
    end
    chk("idle_tready0_vf", {31'd0, bus.m_validflag}, 0);
    mm_hold0 = 1'b0;
    wait_for(0, "rd_accept", n);
    chk("rd_accept_lat", n, 1);
    chk("rd_vf", {31'd0, bus.m_validflag}, 1);
    chk("rd_cmd", {24'd0, bus.m_command}, 32'h9F);
    chk("rd_ctyp", {29'd0, bus.m_commtype}, 1);
    chk("rd_nmiso", {25'd0, bus.m_nmiso_bits}, 24);
    chk("rd_port1_idle", {31'd0, bus.req1_ready}, 0);
    bus.req0_valid = 1'b0;
    wait_for(2, "rd_resp", n);
    chk("rd_data", bus.resp0_data, 32'h00C22017);
    chk("rd_err", {31'd0, bus.resp0_err}, 0);
    @(negedge clk);
    chk("rd_pulse_once", {31'd0, bus.resp0_valid}, 0);
    chk("rd_n_r0", n_r0, 1);
    chk("rd_n_r1", n_r1, 0);
    mm_rdata = 32'h11112222;
    set_req(0, 8'h02, 32'h00123456, 32'hDEADBEEF, 3'd4, 7'd0, 4'd8);
    bus.req0_valid = 1'b1;
    wait_for(0, "fc_accept", n);
    chk("fc_addr", bus.m_address, 32'h00123456);
    chk("fc_din", bus.m_data_in, 32'hDEADBEEF);
    chk("fc_ctyp", {29'd0, bus.m_commtype}, 4);
    chk("fc_dummy", {28'd0, bus.m_dummy_cycles}, 8);
    bus.req0_valid = 1'b0;
    wait_for(2, "fc_resp", n);
    chk("fc_rdata", bus.resp0_data, 32'h11112222);
    @(negedge clk);
    chk("fc_hold_addr", bus.m_address, 32'h00123456);
    chk("fc_hold_din", bus.m_data_in, 32'hDEADBEEF);
    mm_rdata = 32'hA5A50001;
    set_req(1, 8'h0B, 32'h00001000, 32'h0, 3'd2, 7'd32, 4'd8);
    bus.req1_valid = 1'b1;
    wait_for(1, "b2b_accept1", n);
    chk("b2b_cmd1", {24'd0, bus.m_command}, 32'h0B);
    bus.req1_valid = 1'b0;
    wait_for(3, "b2b_resp1", n);
    chk("b2b_rdata1", bus.resp1_data, 32'hA5A50001);
    chk("b2b_vf_gap", {31'd0, bus.m_validflag}, 0);
    mm_rdata = 32'h5A5A0002;
    bus.req1_valid = 1'b1;
    wait_for(1, "b2b_accept2", n);
    chk("b2b_gap", n, 1);
    chk("b2b_no_port0", {31'd0, bus.req0_ready}, 0);
    bus.req1_valid = 1'b0;
    wait_for(3, "b2b_resp2", n);
    chk("b2b_rdata2", bus.resp1_data, 32'h5A5A0002);
    chk("b2b_port0_data_kept", bus.resp0_data, 32'h11112222);
    @(negedge clk);
    chk("b2b_n_r0", n_r0, 2);
    chk("b2b_n_r1", n_r1, 2);
    mm_rdata = 32'hCAFEF00D;
    set_req(0, 8'h03, 32'h00ABCDEF, 32'h0, 3'd2, 7'd32, 4'd0);
    bus.req0_valid = 1'b1;
    wait_for(0, "mr_accept", n);
    bus.req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_busy_tready", {31'd0, bus.m_tready}, 0);
    chk("mr_busy_addr", bus.m_address, 32'h00ABCDEF);
    rst = 1'b1;
    #1;
    chk("mr_addr", bus.m_address, 0);
    chk("mr_ctyp", {29'd0, bus.m_commtype}, 0);
    chk("mr_vf", {31'd0, bus.m_validflag}, 0);
    chk("mr_rdata0", bus.resp0_data, 0);
    chk("mr_rdata1", bus.resp1_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = n_r0;
    repeat (20) @(negedge clk);
    chk("mr_no_resp", n_r0, k);
    chk("mr_resp_low", {31'd0, bus.resp0_valid}, 0);
    mm_rdata = 32'h77778888;
    set_req(0, 8'h05, 32'h00000100, 32'h0, 3'd1, 7'd8, 4'd0);
    set_req(1, 8'h06, 32'h00000200, 32'h0, 3'd1, 7'd8, 4'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int c = 0; c < 400 && g.size() < 4; c++) begin
      @(negedge clk);
      if (bus.req0_ready) g.push_back(0);
      if (bus.req1_ready) g.push_back(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("tie_grants", g.size(), 4);
    for (int i = 0; i < 4; i++) chk("tie_order", i < g.size() ? g[i] : 99, i % 2);
    wait_for(3, "tie_last_resp", n);
    chk("tie_rdata1", bus.resp1_data, 32'h77778888);
    @(negedge clk);
    mm_ack = 1'b0;
    set_req(0, 8'h9F, 32'h0, 32'h0, 3'd1, 7'd24, 4'd0);
    bus.req0_valid = 1'b1;
    wait_for(0, "to_accept", n);
    bus.req0_valid = 1'b0;
    chk("to_vf_rise", {31'd0, bus.m_validflag}, 1);
    chk("to_prev_data", bus.resp0_data, 32'h77778888);
    hi = 1;
    while (bus.m_validflag && hi < 40) begin
      @(negedge clk);
      if (bus.m_validflag) hi++;
    end
    chk("to_vf_len", hi, 16);
    chk("to_resp", {31'd0, bus.resp0_valid}, 1);
    chk("to_err", {31'd0, bus.resp0_err}, 1);
    chk("to_data", bus.resp0_data, 0);
    @(negedge clk);
    chk("to_pulse", {30'd0, bus.resp0_err, bus.resp0_valid}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
